// File: rtl/ext_int_pkg.sv
// Shared encodings for the external-interrupt conditioner: trigger modes,
// debounce FSM states, per-channel status bundle and the event decode.
package ext_int_pkg;

    typedef enum logic [1:0] {
        MODE_RISE  = 2'b00,
        MODE_FALL  = 2'b01,
        MODE_BOTH  = 2'b10,
        MODE_LEVEL = 2'b11
    } int_mode_e;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b10,
        WAIT_LO   = 2'b11
    } deb_state_e;

    typedef struct packed {
        logic level;
        logic pulse;
        logic pending;
    } ch_status_t;

    // lvl is the current debounced level, lvl_d its value one cycle earlier
    function automatic logic irq_event(input int_mode_e m, input logic lvl, input logic lvl_d);
        logic ev;
        ev = 1'b0;
        case (m)
            MODE_RISE:  ev = lvl & ~lvl_d;
            MODE_FALL:  ev = ~lvl & lvl_d;
            MODE_BOTH:  ev = lvl ^ lvl_d;
            MODE_LEVEL: ev = lvl;
            default:    ev = 1'b0;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/ext_int_channel.sv
// One external-interrupt channel: 2-flop synchronizer, debounce FSM,
// trigger-mode event detection and sticky pending flag.
module ext_int_channel
    import ext_int_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pad,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic       ack,
    output ch_status_t status
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             sync;
    deb_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             level_d;
    logic             pulse;
    logic             pending;
    logic             ev;

    assign sync = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], pad};
    end

    // The counter only runs in WAIT states and is cleared before it can
    // exceed DEBOUNCE_CYCLES-1, so it never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            case (state)
                STABLE_LO: if (sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state <= STABLE_HI;
                        level <= 1'b1;
                    end else begin
                        state <= WAIT_HI;
                        cnt   <= CNT_ONE;
                    end
                end
                WAIT_HI: begin
                    if (!sync) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_HI;
                        level <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STABLE_HI: if (!sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state <= STABLE_LO;
                        level <= 1'b0;
                    end else begin
                        state <= WAIT_LO;
                        cnt   <= CNT_ONE;
                    end
                end
                WAIT_LO: begin
                    if (sync) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_LO;
                        level <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

    // Events derive from debounced level history only, so mode/enable
    // changes alone never fabricate an edge.
    assign ev = enable & irq_event(int_mode_e'(mode), level, level_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_d <= 1'b0;
            pulse   <= 1'b0;
            pending <= 1'b0;
        end else begin
            level_d <= level;
            pulse   <= ev;
            pending <= ev | (pending & ~ack);
        end
    end

    assign status.level   = level;
    assign status.pulse   = pulse;
    assign status.pending = pending;

endmodule

// File: rtl/ext_int_conditioner.sv
// Conditions raw INT pins into debounced levels, event strobes and sticky
// requests for the microcontroller int_ext inputs (driven by irq_pending).
module ext_int_conditioner
    import ext_int_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     pad_in,
    input  logic [NUM_CH-1:0]     enable,
    input  logic [2*NUM_CH-1:0]   mode,
    input  logic [NUM_CH-1:0]     ack,
    output logic [NUM_CH-1:0]     level_out,
    output logic [NUM_CH-1:0]     irq_pulse,
    output logic [NUM_CH-1:0]     irq_pending
);

    ch_status_t status [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ext_int_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .pad    (pad_in[i]),
            .enable (enable[i]),
            .mode   (mode[2*i+1:2*i]),
            .ack    (ack[i]),
            .status (status[i])
        );

        assign level_out[i]   = status[i].level;
        assign irq_pulse[i]   = status[i].pulse;
        assign irq_pending[i] = status[i].pending;
    end

endmodule

// File: tb/tb_ext_int_conditioner.sv
// Random + directed bench for ext_int_conditioner against a run-length
// reference model of debounce and event behaviour.
module tb_ext_int_conditioner;

    localparam int NCH = 2;
    localparam int DEB = 4;

    logic           clk;
    logic           reset;
    logic [NCH-1:0] pad_in;
    logic [NCH-1:0] enable;
    logic [2*NCH-1:0] mode;
    logic [NCH-1:0] ack;
    logic [NCH-1:0] level_out;
    logic [NCH-1:0] irq_pulse;
    logic [NCH-1:0] irq_pending;

    ext_int_conditioner #(.NUM_CH(NCH), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk        (clk),
        .reset      (reset),
        .pad_in     (pad_in),
        .enable     (enable),
        .mode       (mode),
        .ack        (ack),
        .level_out  (level_out),
        .irq_pulse  (irq_pulse),
        .irq_pending(irq_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit m_p1 [NCH];   // pad sampled one edge ago
    bit m_p2 [NCH];   // pad sampled two edges ago (what the debouncer sees)
    bit m_level [NCH];
    bit m_prev [NCH];
    int m_run [NCH];
    bit m_pulse [NCH];
    bit m_pend [NCH];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit fires(input int m, input bit lvl, input bit prv);
        case (m)
            0: return lvl && !prv;
            1: return !lvl && prv;
            2: return lvl != prv;
            default: return lvl;
        endcase
    endfunction

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            if (reset) begin
                m_p1[c] = 0; m_p2[c] = 0; m_level[c] = 0; m_prev[c] = 0;
                m_run[c] = 0; m_pulse[c] = 0; m_pend[c] = 0;
            end else begin
                bit ev;
                int md;
                md = int'(mode[2*c +: 2]);
                ev = enable[c] && fires(md, m_level[c], m_prev[c]);
                m_pend[c]  = ev || (m_pend[c] && !ack[c]);
                m_pulse[c] = ev;
                m_prev[c]  = m_level[c];
                // level flips after DEB consecutive differing synchronized samples
                if (m_p2[c] != m_level[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DEB) begin
                        m_level[c] = m_p2[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_p2[c] = m_p1[c];
                m_p1[c] = pad_in[c];
            end
        end
    endtask

    task automatic cycle();
        logic [NCH-1:0] el, ep, eq;
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            el[c] = m_level[c];
            ep[c] = m_pulse[c];
            eq[c] = m_pend[c];
        end
        chk("level_out", 32'(level_out), 32'(el));
        chk("irq_pulse", 32'(irq_pulse), 32'(ep));
        chk("irq_pending", 32'(irq_pending), 32'(eq));
    endtask

    int hold [NCH];
    int rst_left;

    initial begin
        reset  = 1'b1;
        pad_in = '0;
        enable = '1;
        mode   = '0;
        ack    = '0;
        cycle();
        cycle();
        chk("reset_level", 32'(level_out), 32'd0);
        chk("reset_pend", 32'(irq_pending), 32'd0);

        // rising event on ch0: level at edge 6, pulse at edge 7 only, pending until ack
        reset = 1'b0;
        repeat (3) cycle();
        pad_in[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            chk($sformatf("r30_level_e%0d", k), 32'(level_out[0]), 32'(k >= 6));
            chk($sformatf("r30_pulse_e%0d", k), 32'(irq_pulse[0]), 32'(k == 7));
            chk($sformatf("r30_pend_e%0d", k), 32'(irq_pending[0]), 32'(k >= 7));
        end
        ack[0] = 1'b1;
        cycle();
        ack[0] = 1'b0;
        chk("r30_ack_clears", 32'(irq_pending[0]), 32'd0);

        // glitch shorter than the debounce window: no level change
        pad_in[1] = 1'b1;
        repeat (3) cycle();
        pad_in[1] = 1'b0;
        repeat (8) begin
            cycle();
            chk("r31_no_level", 32'(level_out[1]), 32'd0);
            chk("r31_no_pulse", 32'(irq_pulse[1]), 32'd0);
        end

        // reset mid-WAIT_HI, pad held high: level rises 6 edges after release
        pad_in[1] = 1'b1;
        repeat (4) cycle();
        reset = 1'b1;
        cycle();
        chk("r35_in_reset", 32'({level_out, irq_pulse, irq_pending}), 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cycle();
            chk($sformatf("r35_level_e%0d", k), 32'(level_out[1]), 32'(k >= 6));
            chk($sformatf("r35_pulse_e%0d", k), 32'(irq_pulse[1]), 32'(k == 7));
        end

        // randomized traffic
        for (int c = 0; c < NCH; c++) hold[c] = 1;
        rst_left = 0;
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    pad_in[c] = ~pad_in[c];
                    hold[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4))
                                                           : int'($urandom_range(5, 14));
                end
                if ($urandom_range(0, 19) == 0) enable[c] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 59) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
                ack[c] = ($urandom_range(0, 3) == 0);
            end
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) reset = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                rst_left = int'($urandom_range(1, 3));
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ext_int_conditioner.md
EXT_INT_CONDITIONER -- requirements
Module: ext_int_conditioner

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent external-interrupt channels (INT0, INT1).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, legal range 1..65535: consecutive stable synchronized samples required to accept a level change.
REQ-003 SHALL have port clk  input  1: single system clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port pad_in  input  NUM_CH: raw asynchronous interrupt pins.
REQ-006 SHALL have port enable  input  NUM_CH: per-channel event enable.
REQ-007 SHALL have port mode  input  2*NUM_CH: per-channel trigger mode, channel i at bits [2i+1:2i].
REQ-008 SHALL have port ack  input  NUM_CH: per-channel pending-clear strobe from the interrupt controller.
REQ-009 SHALL have port level_out  output  NUM_CH: debounced pin level.
REQ-010 SHALL have port irq_pulse  output  NUM_CH: one-cycle strobe per accepted event.
REQ-011 SHALL have port irq_pending  output  NUM_CH: sticky request to microcontroller int_ext inputs.

Function
REQ-012 Each channel SHALL pass pad_in through a 2-flop synchronizer before any other logic.
REQ-013 Each channel SHALL run a debounce FSM with states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-014 STABLE_LO->WAIT_HI when sync=1, counter loaded 1; STABLE_HI->WAIT_LO symmetric with sync=0.
REQ-015 In WAIT_x: sync still new value -> counter+1; counter reaching DEBOUNCE_CYCLES -> STABLE_x, level_out updated same edge; sync reverts -> back to previous STABLE state, counter cleared, no event.
REQ-016 For DEBOUNCE_CYCLES=1 the FSM SHALL go STABLE_LO->STABLE_HI directly (WAIT states bypassed).
REQ-017 Latency: level_out SHALL change exactly 2+DEBOUNCE_CYCLES clk edges after the first edge sampling a new, thereafter stable, pad_in value.
REQ-018 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); it SHALL never wrap.
REQ-019 Mode 00 rising, 01 falling, 10 both edges of level_out SHALL be events; 11 level-high: event every cycle level_out=1.
REQ-020 irq_pulse SHALL be high for exactly the one cycle following the edge on which level_out changes (edge modes), or every cycle level_out=1 (mode 11), gated by enable.
REQ-021 irq_pending SHALL set on any irq_pulse and clear on ack; simultaneous event and ack SHALL leave it set.
REQ-022 ack while pending=0 SHALL have no effect; enable=0 SHALL block new events but not clear pending.
REQ-023 Mode or enable change SHALL take effect next cycle and SHALL NOT itself produce an event.
REQ-024 Channels SHALL be fully independent; no shared counters.

Reset
REQ-025 On reset: sync flops 0, FSM STABLE_LO, counter 0, level_out 0, irq_pulse 0, irq_pending 0, asynchronously.
REQ-026 Reset mid-WAIT SHALL abandon the pending transition; a pad held high through reset SHALL yield a rising event 2+DEBOUNCE_CYCLES edges after reset release.

Structure
REQ-027 Mode encodings (MODE_RISE, MODE_FALL, MODE_BOTH, MODE_LEVEL) and FSM state encodings SHALL live in shared package/include ext_int_pkg.
REQ-028 Per-channel logic SHALL be sub-module ext_int_channel, instantiated NUM_CH times via generate.
REQ-029 Block SHALL sit between top-level INT pins and microcontroller int_ext inputs; irq_pending drives int_ext.

Verification (DEBOUNCE_CYCLES=4, NUM_CH=2)
REQ-030 ch0 mode 00, pad 0->1 held -> level_out=1 at edge 6, irq_pulse one cycle at 7, pending set until ack.
REQ-031 ch0 pad high 3 cycles then low -> no level change, no pulse, counter back to 0.
REQ-032 ch1 mode 10, pad toggles with 10-cycle holds -> pulse on every toggle, each 6 edges after sampling.
REQ-033 pending=1, new event and ack same cycle -> pending remains 1; ack next cycle alone -> 0.
REQ-034 mode 11, enable=0 then 1 while level high -> no pulses while disabled, pulses every cycle after.
REQ-035 pad high, reset asserted mid-WAIT_HI then released -> outputs 0 in reset, rising event 6 edges after release.
